// File: rtl/axis_pkt_checksum.sv
// Byte-stream packet forwarder that appends a two's-complement checksum byte
// to every packet, so each emitted packet sums to 0x00 modulo 256.
module axis_pkt_checksum #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [15:0]       pkt_count,
  output logic              trunc_err,
  output logic              state_dbg
);

  // Handshake: a byte moves on a rising edge where valid && ready are both 1.
  // s_ready never looks at s_valid; m_data/m_last/m_valid stay frozen while
  // m_valid && !m_ready.

  typedef enum logic {
    PASS = 1'b0,
    CSUM = 1'b1
  } state_e;

  localparam logic [8:0] MAX_LEN_L = 9'(MAX_LEN);

  state_e            state;
  state_e            state_nxt;
  logic [DATA_W-1:0] sum;
  logic [7:0]        byte_cnt;
  logic [8:0]        cnt_next;
  logic              slot_free;
  logic              accept;
  logic              len_hit;
  logic [DATA_W-1:0] csum_val;

  assign slot_free = !m_valid || m_ready;
  assign s_ready   = rst && (state == PASS) && slot_free;
  assign accept    = s_valid && s_ready;
  assign cnt_next  = {1'b0, byte_cnt} + 9'd1;
  assign len_hit   = (cnt_next == MAX_LEN_L);
  assign csum_val  = ~sum + {{(DATA_W-1){1'b0}}, 1'b1};
  assign state_dbg = (state == CSUM);

  always_comb begin
    state_nxt = state;
    case (state)
      PASS: if (accept && (s_last || len_hit)) state_nxt = CSUM;
      CSUM: if (slot_free) state_nxt = PASS;
      default: state_nxt = PASS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= PASS;
    else      state <= state_nxt;
  end

  // Checksum load takes priority; in CSUM no input can be accepted anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      sum       <= '0;
      byte_cnt  <= '0;
      pkt_count <= '0;
      trunc_err <= 1'b0;
    end else begin
      trunc_err <= accept && len_hit && !s_last;
      if (state == CSUM && slot_free) begin
        m_data    <= csum_val;
        m_valid   <= 1'b1;
        m_last    <= 1'b1;
        sum       <= '0;
        byte_cnt  <= '0;
        pkt_count <= pkt_count + 16'd1;
      end else if (accept) begin
        m_data   <= s_data;
        m_valid  <= 1'b1;
        m_last   <= 1'b0;
        sum      <= sum + s_data;
        byte_cnt <= cnt_next[7:0];
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule
